// File: rtl/processor_pkg.sv
// Shared types for the fetch/data memory arbiter: access FSM states, port
// ownership encoding and the two-way round-robin pick.
package processor_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // On a tie the port that did not win last time gets the memory.
  function automatic owner_t rr_pick(input logic req_if, input logic req_dm,
                                     input owner_t last);
    owner_t pick;
    if (req_if && req_dm) begin
      pick = (last == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (req_dm) begin
      pick = OWN_DM;
    end else begin
      pick = OWN_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; remembers the last winner so that
// simultaneous requests alternate between fetch and data ports.
module rr_arbiter_2
  import processor_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   req_if,
  input  logic   req_dm,
  output logic   win,
  output owner_t win_owner
);

  owner_t last_q, last_d;

  always_comb begin
    win       = req_if | req_dm;
    win_owner = rr_pick(req_if, req_dm, last_q);
    last_d    = win ? win_owner : last_q;
  end

  // Resetting to the data port lets fetch win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_DM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports.
// Each access is one ACCESS cycle; read data returns the following cycle.
module mem_arbiter
  import processor_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic   in_access;
  logic   elig_if, elig_dm;
  logic   win;
  owner_t win_owner;

  always_comb begin
    in_access = (state_q == ACCESS);
    if_gnt    = in_access && (owner_q == OWN_IF);
    dm_gnt    = in_access && (owner_q == OWN_DM);
    busy      = in_access;
    mem_addr  = in_access ? addr_q  : '0;
    mem_wdata = in_access ? wdata_q : '0;
    mem_write = in_access && we_q;
    if_rvalid = if_rvalid_q;
    dm_rvalid = dm_rvalid_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    // A port being served this cycle may not compete for the next one.
    elig_if   = if_req & ~if_gnt;
    elig_dm   = dm_req & ~dm_gnt;
  end

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_if    (elig_if),
    .req_dm    (elig_dm),
    .win       (win),
    .win_owner (win_owner)
  );

  always_comb begin
    state_d     = win ? ACCESS : IDLE;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    if (win) begin
      owner_d = win_owner;
      if (win_owner == OWN_IF) begin
        addr_d  = if_addr;
        we_d    = 1'b0;
        wdata_d = '0;
      end else begin
        addr_d  = dm_addr;
        we_d    = dm_we;
        wdata_d = dm_wdata;
      end
    end

    if (in_access) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata;
      end else begin
        dm_rvalid_d = 1'b1;
        dm_rdata_d  = we_q ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory and
// per-port read-data scoreboards.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_write, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_dm_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory: combinational read, write at posedge; preloaded on first edge.
  logic [DW-1:0] cells [256];
  logic          preloaded = 1'b0;
  assign mem_rdata = cells[mem_addr];

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) cells[i] <= {8'hC0, i[7:0], 8'h5A, i[7:0]};
      cells[4]  <= 32'hDEADBEEF;
      cells[32] <= 32'hA5A50020;
      cells[48] <= 32'h5A5A0030;
      cells[64] <= 32'h11112222;
      preloaded <= 1'b1;
    end else if (mem_write) begin
      cells[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("gnt_exclusive", {31'b0, if_gnt & dm_gnt}, 32'd0);
      chk("rvalid_exclusive", {31'b0, if_rvalid & dm_rvalid}, 32'd0);
      if (if_rvalid) begin
        if (exp_if_q.size() == 0) chk("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'd0);
        else chk("if_rdata_sb", if_rdata, exp_if_q.pop_front());
      end
      if (dm_rvalid) begin
        if (exp_dm_q.size() == 0) chk("dm_rvalid_unexpected", {31'b0, dm_rvalid}, 32'd0);
        else chk("dm_rdata_sb", dm_rdata, exp_dm_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_dm_gnt", {31'b0, dm_gnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);

    // Fetch from cell 4
    @(negedge clk);
    reset_n = 1'b1;
    if_req  = 1'b1;
    if_addr = 8'h04;
    exp_if_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    chk("fetch_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("fetch_dm_gnt", {31'b0, dm_gnt}, 32'd0);
    chk("fetch_busy", {31'b0, busy}, 32'd1);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h04);
    chk("fetch_mem_write", {31'b0, mem_write}, 32'd0);
    chk("fetch_rvalid_early", {31'b0, if_rvalid}, 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("fetch_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("fetch_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("fetch_gnt_done", {31'b0, if_gnt}, 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);

    // Store 12345678 to cell 0x10, then load it back
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 8'h10;
    dm_wdata = 32'h12345678;
    exp_dm_q.push_back(32'h0);
    @(posedge clk); #1;
    chk("store_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("store_mem_write", {31'b0, mem_write}, 32'd1);
    chk("store_mem_addr", 32'(mem_addr), 32'h10);
    chk("store_mem_wdata", mem_wdata, 32'h12345678);
    dm_we    = 1'b0;
    dm_wdata = '0;
    @(posedge clk); #1;
    chk("store_write_drop", {31'b0, mem_write}, 32'd0);
    chk("no_consec_dm_gnt", {31'b0, dm_gnt}, 32'd0);
    chk("store_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("store_dm_rdata", dm_rdata, 32'd0);
    chk("store_cell16", cells[16], 32'h12345678);
    chk("if_rdata_hold", if_rdata, 32'hDEADBEEF);
    exp_dm_q.push_back(32'h12345678);
    @(posedge clk); #1;
    chk("load_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("load_mem_write", {31'b0, mem_write}, 32'd0);
    chk("load_mem_addr", 32'(mem_addr), 32'h10);
    dm_req = 1'b0;
    @(posedge clk); #1;
    chk("load_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("load_dm_rdata", dm_rdata, 32'h12345678);
    @(posedge clk); #1;
    chk("load_rvalid_pulse", {31'b0, dm_rvalid}, 32'd0);
    chk("dm_rdata_hold", dm_rdata, 32'h12345678);

    // Both ports held from reset release: strict alternation, fetch first
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst2_dm_rdata", dm_rdata, 32'd0);
    chk("rst2_if_rdata", if_rdata, 32'd0);
    if_req  = 1'b1;
    if_addr = 8'h20;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 8'h30;
    repeat (3) exp_if_q.push_back(32'hA5A50020);
    repeat (3) exp_dm_q.push_back(32'h5A5A0030);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("alt_if_gnt", {31'b0, if_gnt}, 32'(i % 2 == 0));
      chk("alt_dm_gnt", {31'b0, dm_gnt}, 32'(i % 2 == 1));
      if (i == 4) if_req = 1'b0;
      if (i == 5) dm_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("alt_last_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("alt_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("if_sb_drained", 32'(exp_if_q.size()), 32'd0);
    chk("dm_sb_drained", 32'(exp_dm_q.size()), 32'd0);

    // Reset in the middle of a store aborts it
    @(negedge clk);
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 8'h40;
    dm_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("abort_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("abort_mem_write_pre", {31'b0, mem_write}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
    chk("abort_dm_gnt_drop", {31'b0, dm_gnt}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_rvalid", {31'b0, dm_rvalid}, 32'd0);
    end
    chk("abort_cell64", cells[64], 32'h11112222);
    chk("abort_dm_sb_empty", 32'(exp_dm_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory word-address width (256 cells).
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-004 Port clk  input  1  rising-edge clock shared with memory and register file.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port if_req  input  1  fetch request, held until if_gnt seen.
REQ-007 Port if_addr  input  ADDR_W  fetch word address.
REQ-008 Port if_gnt  output  1  fetch access in progress; high exactly one cycle.
REQ-009 Port if_rvalid  output  1  if_rdata valid; one-cycle pulse.
REQ-010 Port if_rdata  output  DATA_W  fetched word.
REQ-011 Port dm_req  input  1  data request, held until dm_gnt seen.
REQ-012 Port dm_we  input  1  1 = store, 0 = load.
REQ-013 Port dm_addr  input  ADDR_W  data word address.
REQ-014 Port dm_wdata  input  DATA_W  store data.
REQ-015 Port dm_gnt  output  1  data access in progress; high exactly one cycle.
REQ-016 Port dm_rvalid  output  1  load data valid or store complete; one-cycle pulse.
REQ-017 Port dm_rdata  output  DATA_W  loaded word; 0 after a store.
REQ-018 Port mem_addr  output  ADDR_W  address to the single-port memory.
REQ-019 Port mem_wdata  output  DATA_W  write data to memory.
REQ-020 Port mem_write  output  1  memory write enable, sampled by memory at posedge.
REQ-021 Port mem_rdata  input  DATA_W  combinational read data from memory.
REQ-022 Port busy  output  1  high while in ACCESS.

Function
REQ-023 States SHALL be IDLE and ACCESS.
REQ-024 Arbitration point: every posedge in IDLE and the final posedge of ACCESS; eligible requests are if_req & ~if_gnt and dm_req & ~dm_gnt.
REQ-025 One eligible request: that port wins; two: the port not granted last wins (round-robin); none: go/stay IDLE.
REQ-026 On a win the block SHALL latch addr, we, wdata and owner, enter ACCESS, and raise the owner's gnt for that one ACCESS cycle.
REQ-027 During ACCESS mem_addr = latched addr, mem_wdata = latched wdata, mem_write = latched we (always 0 for fetch owner).
REQ-028 Outside ACCESS mem_write, mem_addr and mem_wdata SHALL be 0.
REQ-029 At the posedge ending ACCESS the block SHALL capture mem_rdata (load/fetch) or 0 (store) into the owner's rdata and pulse the owner's rvalid the next cycle.
REQ-030 Latency: request sampled at posedge N -> gnt cycle N+1 -> rvalid cycle N+2.
REQ-031 Back-to-back ACCESS SHALL occur when the other port is eligible at ACCESS end; the same port can never be granted in consecutive cycles.
REQ-032 rdata outputs SHALL hold their last value until the next rvalid for that port.
REQ-033 if_gnt and dm_gnt SHALL never be high together; neither may rvalid.
REQ-034 Worst-case wait for a held request SHALL be 2 cycles from first sampling to gnt.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, all gnt/rvalid/busy/mem_write to 0, rdata/mem_addr/mem_wdata to 0, last-granted = dm (fetch wins first tie).
REQ-036 Reset during ACCESS SHALL abort it: no memory write, no rvalid after release.
REQ-037 First arbitration SHALL be the first posedge with reset_n high.

Structure
REQ-038 Shared package processor_pkg SHALL hold the state enum (IDLE, ACCESS) and owner encoding (OWN_IF=0, OWN_DM=1).
REQ-039 Sub-module rr_arbiter_2 SHALL contain the two-requester round-robin pick and last-granted register.

Verification
REQ-040 Reset, then if_req=1, if_addr=8'h04, cells[4]=32'hDEADBEEF -> if_gnt next cycle, if_rvalid following cycle, if_rdata=32'hDEADBEEF.
REQ-041 dm_req=1, dm_we=1, dm_addr=8'h10, dm_wdata=32'h12345678 -> mem_write=1 only in gnt cycle, cells[16]=32'h12345678, dm_rvalid pulse, dm_rdata=0.
REQ-042 if_req and dm_req both held from reset release -> grants IF, DM, IF, DM alternating in consecutive cycles, never both gnt.
REQ-043 dm load to 8'h10 directly after store to 8'h10 -> dm_rdata=32'h12345678.
REQ-044 reset_n pulsed low during a store's ACCESS cycle -> mem_write drops at once, memory cell unchanged, no dm_rvalid.
